// File: rtl/dat_mem_arbiter.sv
// ---------------------------------------------------------------------------
// dat_mem_arbiter
//   Lets N_REQ requesters (core load/store unit, init loader, debug port)
//   share one single-port data memory. The memory has a combinational read
//   and a clocked write. Each grant performs exactly one access and ends
//   with a one-cycle ack pulse. Read data is registered and held until the
//   next read completes.
//
//   Build option: define DAT_ARB_FIXED_PRI_EN to replace round-robin with
//   fixed priority, where the lowest index wins and the rotation pointer is
//   removed (w_rr_ptr reads as 0). Left undefined, the arbiter uses
//   round-robin.
//
// Ports
//   i_clk           system clock, all state on posedge
//   i_rst_n         synchronous active-low reset
//   i_req           per-requester request, held until ack
//   i_we            per-requester write enable (1=write, 0=read)
//   i_addr          packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_wdata         packed write data, requester i at [i*DATA_W +: DATA_W]
//   o_ack           one-cycle completion pulse to the served requester
//   o_rdata         registered read data, valid in ack cycle
//   o_mem_wr_en     memory write enable
//   o_mem_addr      memory address
//   o_mem_dat_in    memory write data
//   i_mem_dat_out   memory read data (combinational)
//
// FSM states
//   state    | meaning
//   S_IDLE   | arbitrate among pending requests, latch the winner
//   S_ACCESS | drive the memory; write commits / read data captured at end
//   S_RESP   | ack pulse to the served requester, no arbitration
// ---------------------------------------------------------------------------
module dat_mem_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  output logic [N_REQ-1:0]          o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_wr_en,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_dat_in,
  input  logic [DATA_W-1:0]         i_mem_dat_out
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [PTR_W-1:0]    w_rr_ptr;
  logic [PTR_W-1:0]    r_cur_id;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic                r_cur_we;
  logic [DATA_W-1:0]   r_cur_wdata;
  logic [N_REQ-1:0]    r_ack;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_grant_found;
  logic [PTR_W-1:0]    w_grant_id;
  logic                w_latch;
  logic                w_rdata_load;
  logic [N_REQ-1:0]    w_ack_nxt;
  logic                w_mem_wr_en;

  // -------------------------------------------------------------------------
  // Rotation pointer (round-robin only)
  // -------------------------------------------------------------------------
`ifdef DAT_ARB_FIXED_PRI_EN
  assign w_rr_ptr = '0;
`else
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    w_rr_ptr_nxt;

  always_comb begin
    if (w_grant_id == PTR_W'(N_REQ - 1)) begin
      w_rr_ptr_nxt = '0;
    end else begin
      w_rr_ptr_nxt = w_grant_id + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_latch) begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  // -------------------------------------------------------------------------
  // Winner search: first asserted request starting at w_rr_ptr, wrapping.
  // With fixed priority the pointer is 0, so this reduces to lowest index.
  // -------------------------------------------------------------------------
  always_comb begin
    int v_idx;
    v_idx         = 0;
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = int'(w_rr_ptr) + i;
      if (v_idx >= N_REQ) begin
        v_idx = v_idx - N_REQ;
      end
      if (!w_grant_found && i_req[v_idx]) begin
        w_grant_found = 1'b1;
        w_grant_id    = PTR_W'(v_idx);
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = w_grant_found ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // -------------------------------------------------------------------------
  always_comb begin
    w_latch      = 1'b0;
    w_rdata_load = 1'b0;
    w_ack_nxt    = '0;
    w_mem_wr_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_latch = w_grant_found;
      end
      S_ACCESS: begin
        // Gating with i_rst_n keeps a reset that lands mid-access from
        // committing a write on the same edge that clears the FSM.
        w_mem_wr_en          = r_cur_we & i_rst_n;
        w_rdata_load         = ~r_cur_we;
        w_ack_nxt[r_cur_id]  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Latched access, ack pulse and read data
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cur_id    <= '0;
      r_cur_addr  <= '0;
      r_cur_we    <= 1'b0;
      r_cur_wdata <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_latch) begin
        r_cur_id    <= w_grant_id;
        r_cur_addr  <= i_addr[int'(w_grant_id)*ADDR_W +: ADDR_W];
        r_cur_we    <= i_we[w_grant_id];
        r_cur_wdata <= i_wdata[int'(w_grant_id)*DATA_W +: DATA_W];
      end
      r_ack <= w_ack_nxt;
      if (w_rdata_load) begin
        r_rdata <= i_mem_dat_out;
      end
    end
  end

  assign o_ack        = r_ack;
  assign o_rdata      = r_rdata;
  assign o_mem_wr_en  = w_mem_wr_en;
  assign o_mem_addr   = r_cur_addr;
  assign o_mem_dat_in = r_cur_wdata;

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dat_mem_arbiter
//   Directed bench for dat_mem_arbiter with two requesters and a behavioural
//   256x8 memory (combinational read, clocked write). Memory contents start
//   as mem[a] = a, except that mem[70] = 0x08.
// ---------------------------------------------------------------------------
module tb_dat_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_dat_in;
  logic [7:0]  mem_dat_out;

  logic [7:0]  mem [256];
  logic        preload;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  logic [1:0] exp_ack;
  logic [7:0] exp_rd;

  dat_mem_arbiter #(.N_REQ(2), .ADDR_W(8), .DATA_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_we          (we),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_ack         (ack),
    .o_rdata       (rdata),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_addr    (mem_addr),
    .o_mem_dat_in  (mem_dat_in),
    .i_mem_dat_out (mem_dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) begin
        mem[a] <= (a == 70) ? 8'h08 : 8'(a);
      end
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_dat_in;
    end
  end

  assign mem_dat_out = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until ack is seen, 0 if none in budget.
  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    preload = 1'b1;
    req     = 2'b00;
    we      = 2'b00;
    addr    = 16'h0000;
    wdata   = 16'h0000;

    // 1: reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_dat_in", 32'(mem_dat_in), 32'h0);
    rst_n   = 1'b1;
    preload = 1'b0;
    @(negedge clk);

    // 2: req0 write 0x55 to 60, then read it back
    req = 2'b01; we = 2'b01; addr = {8'd0, 8'd60}; wdata = {8'h00, 8'h55};
    @(negedge clk);
    chk("wr_access_wr_en", 32'(mem_wr_en), 32'h1);
    chk("wr_access_addr", 32'(mem_addr), 32'd60);
    chk("wr_access_din", 32'(mem_dat_in), 32'h55);
    chk("wr_access_ack", 32'(ack), 32'h0);
    @(negedge clk);
    chk("wr_resp_ack", 32'(ack), 32'h1);
    chk("wr_resp_wr_en", 32'(mem_wr_en), 32'h0);
    chk("wr_resp_rdata", 32'(rdata), 32'h0);
    chk("wr_mem60", 32'(mem[60]), 32'h55);
    we = 2'b00;
    wait_ack(6, lat);
    chk("rd60_latency", 32'(lat), 32'd3);
    chk("rd60_ack", 32'(ack), 32'h1);
    chk("rd60_rdata", 32'(rdata), 32'h55);
    req = 2'b00;
    @(negedge clk);
    chk("idle_ack_clear", 32'(ack), 32'h0);

    // 3: both read from reset, addr 61 / 62
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b11; we = 2'b00; addr = {8'd62, 8'd61};
    wait_ack(6, lat);
    chk("both_first_latency", 32'(lat), 32'd2);
    chk("both_first_ack", 32'(ack), 32'h1);
    chk("both_first_rdata", 32'(rdata), 32'h3D);
    req = 2'b10;
    wait_ack(6, lat);
    chk("both_second_latency", 32'(lat), 32'd3);
    chk("both_second_ack", 32'(ack), 32'h2);
    chk("both_second_rdata", 32'(rdata), 32'h3E);
    req = 2'b00;
    @(negedge clk);
    chk("both_rr_ptr", 32'(dut.w_rr_ptr), 32'h0);

    // 4: both held for 6 accesses
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_ack(8, lat);
`ifdef DAT_ARB_FIXED_PRI_EN
      exp_ack = 2'b01;
`else
      exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_rd = (exp_ack == 2'b01) ? 8'h3D : 8'h3E;
      chk($sformatf("rot%0d_latency", k), 32'(lat), (k == 0) ? 32'd2 : 32'd3);
      chk($sformatf("rot%0d_ack", k), 32'(ack), 32'(exp_ack));
      chk($sformatf("rot%0d_rdata", k), 32'(rdata), 32'(exp_rd));
    end
    req = 2'b00;
    @(negedge clk);

    // 5: req1 write 0xAA to 70, reset lands during ACCESS
    req = 2'b10; we = 2'b10; addr = {8'd70, 8'd61}; wdata = {8'hAA, 8'h00};
    @(negedge clk);
    chk("rstmid_pre_wr_en", 32'(mem_wr_en), 32'h1);
    chk("rstmid_pre_addr", 32'(mem_addr), 32'd70);
    chk("rstmid_pre_din", 32'(mem_dat_in), 32'hAA);
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    chk("rstmid_wr_en_gated", 32'(mem_wr_en), 32'h0);
    @(negedge clk);
    chk("rstmid_ack", 32'(ack), 32'h0);
    chk("rstmid_mem_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_mem70", 32'(mem[70]), 32'h08);
    chk("rstmid_ack_after", 32'(ack), 32'h0);
    chk("rstmid_rr_ptr", 32'(dut.w_rr_ptr), 32'h0);

    // 6: req0 write 0x11 to 72 served first, then req1 reads 72
    req = 2'b11; we = 2'b01; addr = {8'd72, 8'd72}; wdata = {8'h00, 8'h11};
    wait_ack(6, lat);
    chk("wr72_latency", 32'(lat), 32'd2);
    chk("wr72_ack", 32'(ack), 32'h1);
    chk("wr72_rdata_unchanged", 32'(rdata), 32'h0);
    req = 2'b10;
    wait_ack(6, lat);
    chk("rd72_latency", 32'(lat), 32'd3);
    chk("rd72_ack", 32'(ack), 32'h2);
    chk("rd72_rdata", 32'(rdata), 32'h11);
    chk("rd72_mem72", 32'(mem[72]), 32'h11);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("final_ack", 32'(ack), 32'h0);
    chk("final_rdata_held", 32'(rdata), 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
